// File: rtl/fft_frame_capture.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_capture
// Brief    : AXIS receiver that captures one FFT output frame into a
//            word-addressed buffer for register readback.
// Revision : 1.0
// ============================================================================
module fft_frame_capture #(
    parameter int NFFT  = 8,
    parameter int CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        s_tvalid,
    output logic                        s_tready,
    input  logic                        s_tlast,
    input  logic [63:0]                 s_tdata,
    input  logic                        arm,
    input  logic                        clr_err,
    input  logic [$clog2(NFFT*2)-1:0]   r_addr,
    output logic [31:0]                 r_data,
    output logic                        receiving,
    output logic                        frame_done,
    output logic [CNT_W-1:0]            frame_count,
    output logic                        err_early,
    output logic                        err_missing
);

    localparam int c_IDX_W = $clog2(NFFT);
    localparam int c_ADDR_W = $clog2(NFFT*2);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NFFT - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RECV  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_frame_done;
    logic [CNT_W-1:0]   r_frame_count;
    logic               r_err_early;
    logic               r_err_missing;

    // One 64-bit entry per sample; even word is the real part, odd the imaginary.
    logic [63:0]        r_mem [0:NFFT-1];

    logic               w_ready;
    logic               w_beat;
    logic               w_write;
    logic               w_is_last_idx;
    logic               w_set_early;
    logic               w_set_missing;
    logic               w_commit;
    logic [63:0]        w_rd_word;

    assign w_ready       = (r_state == c_RECV) || (r_state == c_DRAIN);
    assign w_beat        = s_tvalid && w_ready;
    assign w_is_last_idx = (r_idx == c_LAST_IDX);

    // A beat coinciding with arm belongs to the abandoned frame and is dropped.
    assign w_write       = w_beat && !arm && (r_state == c_RECV);
    assign w_set_early   = w_write && s_tlast && !w_is_last_idx;
    assign w_set_missing = w_write && !s_tlast && w_is_last_idx;
    assign w_commit      = w_beat && !arm && s_tlast &&
                           ((r_state == c_DRAIN) || w_is_last_idx);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_IDLE;
            r_idx   <= '0;
        end else if (arm) begin
            r_state <= c_RECV;
            r_idx   <= '0;
        end else begin
            case (r_state)
                c_RECV: begin
                    if (w_beat) begin
                        if (s_tlast && w_is_last_idx) begin
                            r_state <= c_DONE;
                        end else if (s_tlast) begin
                            r_state <= c_IDLE;
                        end else if (w_is_last_idx) begin
                            r_state <= c_DRAIN;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                c_DRAIN: begin
                    if (w_beat && s_tlast) begin
                        r_state <= c_DONE;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_frame_done <= w_commit;
            if (w_commit) begin
                r_frame_count <= r_frame_count + 1'b1;
            end
        end
    end

    // A new error event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err_early   <= 1'b0;
            r_err_missing <= 1'b0;
        end else begin
            r_err_early   <= (r_err_early   && !clr_err) || w_set_early;
            r_err_missing <= (r_err_missing && !clr_err) || w_set_missing;
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_idx] <= s_tdata;
        end
    end

    assign w_rd_word = r_mem[r_addr[c_ADDR_W-1:1]];
    assign r_data    = r_addr[0] ? w_rd_word[63:32] : w_rd_word[31:0];

    assign s_tready    = w_ready;
    assign receiving   = w_ready;
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;
    assign err_early   = r_err_early;
    assign err_missing = r_err_missing;

endmodule
`default_nettype wire

// File: doc/fft_frame_capture.md
Name: fft_frame_capture

Overview:
- AXIS receiver that captures one complete FFT output frame of NFFT complex samples into a word-addressed buffer for register-mapped readback over up_axi.
- Sits between the FFT core's output stream and the register read mux, on the up_clk domain.
- Adds explicit arming, frame-length checking against tlast, and drain-on-overrun, so a malformed frame never stalls the core.

Parameters:
- NFFT, 8: samples per frame; power of two, at least 2. Buffer holds NFFT*2 32-bit words.
- CNT_W, 16: width of the completed-frame counter.

Ports:
- clk  in  1  core clock, same as up_clk.
- resetn  in  1  asynchronous active-low reset.
- s_tvalid  in  1  AXIS sample valid from the FFT core.
- s_tready  out  1  AXIS ready to the FFT core.
- s_tlast  in  1  AXIS last beat of frame.
- s_tdata  in  64  sample; [31:0] is the real part, [63:32] is the imaginary part.
- arm  in  1  single-cycle pulse; start capture of the next frame.
- clr_err  in  1  single-cycle pulse; clear the sticky error flags.
- r_addr  in  $clog2(NFFT*2)  buffer word read address.
- r_data  out  32  buffer word, combinational from r_addr.
- receiving  out  1  high while in RECV or DRAIN.
- frame_done  out  1  one-cycle pulse when a frame is committed.
- frame_count  out  CNT_W  number of committed frames; wraps modulo 2^CNT_W.
- err_early  out  1  sticky: tlast arrived before NFFT beats.
- err_missing  out  1  sticky: NFFT beats arrived without tlast on the last one.

Behaviour:
- Reset values: state IDLE, s_tready 0, receiving 0, frame_done 0, frame_count 0, err_early 0, err_missing 0, beat index 0.
  - Buffer RAM is not reset; r_data after reset returns stale or X contents.
- A beat is accepted when s_tvalid and s_tready are both high.
  - Beat k writes word 2k with s_tdata[31:0] and word 2k+1 with s_tdata[63:32].
  - Both words are written on the clock edge of the handshake.
- r_data = mem[r_addr], combinational with zero latency.
  - A read in the same cycle as a write to the same address returns the old value.
  - r_addr values of NFFT*2 or above never occur (non-power-of-two is not supported).
- State IDLE: s_tready=0.
  - arm -> RECV, index=0.
- State RECV: s_tready=1, receiving=1. On each beat, write the words, then:
  - s_tlast and index==NFFT-1 -> DONE; pulse frame_done and increment frame_count on the following cycle.
  - s_tlast and index<NFFT-1 -> set err_early, go to IDLE, no frame_done, frame_count unchanged.
  - no s_tlast and index==NFFT-1 -> set err_missing, go to DRAIN. The buffer holds a complete frame.
  - otherwise index++.
- State DRAIN: s_tready=1, receiving=1. Beats are accepted and discarded, never written.
  - A beat with s_tlast -> DONE, with the frame_done pulse and frame_count increment.
- State DONE: s_tready=0, and the buffer is stable for readback.
  - arm -> RECV, index=0.
- arm while in RECV or DRAIN restarts the capture: index=0, next state RECV.
  - A beat handshaked in the same cycle as arm is discarded (not written) and raises no error.
- clr_err clears both sticky flags.
  - If clr_err coincides with a new error event, the set wins.
- frame_done is asserted exactly one cycle, registered, in the first cycle of DONE.
- Asynchronous reset at any time returns every state and output to its reset value immediately.
  - A partially written buffer is not scrubbed.
- s_tdata is ignored unless a handshake occurs. s_tready never depends combinationally on s_tvalid.

Test Plan:
- Normal frame, NFFT=8:
  - Stimulus: reset, arm, 8 beats with tdata={k+0x100, k} for k=0..7, tlast on beat 7.
  - Required: frame_done pulses once, frame_count=1, r_addr 6 -> 0x3, r_addr 7 -> 0x103, s_tready=0 in DONE, errors 0.
- Backpressure and gaps: same frame with s_tvalid toggled 1/0 every cycle.
  - Required: identical buffer contents to the normal frame; done exactly after the 8th accepted beat.
- Early tlast: arm, then 5 beats with tlast on beat 4.
  - Required: err_early=1, state IDLE (s_tready=0), frame_count unchanged, no frame_done.
  - Then clr_err -> err_early=0.
- Missing tlast: arm, then 11 beats with tlast only on beat 10.
  - Required: err_missing=1, words 0..15 hold beats 0..7, beats 8..10 accepted and dropped, frame_done after beat 10, frame_count increments.
- Re-arm and wrap with CNT_W=2:
  - 5 good frames -> frame_count reads 1.
  - arm asserted mid-frame at beat 3 together with a valid beat -> that beat is not written, index restarts, the next 8 beats form the frame.
- Async reset mid-RECV after beat 2:
  - Required: s_tready, receiving and frame_count drop immediately; after release, state is IDLE and a new arm captures correctly.
